// File: rtl/door_lock_pkg.sv
// Shared types and constants for the door lock controller.
package door_lock_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GOT1    = 3'd1,
    GOT2    = 3'd2,
    OPEN    = 3'd3,
    ERR     = 3'd4,
    LOCKOUT = 3'd5
  } state_t;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] DEF_CODE0 = 8'h48;
  localparam logic [7:0] DEF_CODE1 = 8'hD9;
  localparam logic [7:0] DEF_CODE2 = 8'hC1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/door_lock_key_event.sv
// Keypad edge detector: one event per new nonzero key value.
import door_lock_pkg::*;

module door_lock_key_event (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key,
  output logic       evt,
  output logic [7:0] evt_code
);

  logic [7:0] key_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) key_q <= KEY_NONE;
    else      key_q <= key;
  end

  // Held keys and release to 00 are not events
  assign evt      = (key != key_q) && (key != KEY_NONE);
  assign evt_code = key;

endmodule

// File: rtl/door_lock_ctrl.sv
// Three-code combination lock FSM with error hold and timed lockout.
// Optional auto-relock from OPEN is enabled by DOOR_LOCK_AUTO_RELOCK_EN.
import door_lock_pkg::*;

module door_lock_ctrl #(
  parameter logic [7:0] CODE0          = DEF_CODE0,
  parameter logic [7:0] CODE1          = DEF_CODE1,
  parameter logic [7:0] CODE2          = DEF_CODE2,
  parameter int         ERR_CYCLES     = 4,
  parameter int         MAX_FAILS      = 3,
  parameter int         LOCKOUT_CYCLES = 16,
  parameter int         UNLOCK_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key,
  output logic       locked,
  output logic       unlocked,
  output logic       error
);

  localparam int TW = $clog2(max3(ERR_CYCLES, LOCKOUT_CYCLES, UNLOCK_CYCLES) + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);

  localparam logic [TW-1:0] ERR_LOAD  = TW'(ERR_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAILS);
`ifdef DOOR_LOCK_AUTO_RELOCK_EN
  localparam logic [TW-1:0] UNLOCK_LOAD = TW'(UNLOCK_CYCLES - 1);
`endif

  logic          evt;
  logic [7:0]    evt_code;
  state_t        state, state_n;
  logic [FW-1:0] fail_cnt, fail_n;
  logic [TW-1:0] timer, timer_n;
  logic          go_err;

  door_lock_key_event u_key_event (
    .clk      (clk),
    .rst      (rst),
    .key      (key),
    .evt      (evt),
    .evt_code (evt_code)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fail_cnt <= '0;
      timer    <= '0;
    end else begin
      state    <= state_n;
      fail_cnt <= fail_n;
      timer    <= timer_n;
    end
  end

  always_comb begin
    state_n = state;
    fail_n  = fail_cnt;
    timer_n = timer;
    go_err  = 1'b0;
    case (state)
      IDLE: if (evt) begin
        if (evt_code == CODE0) state_n = GOT1;
        else                   go_err  = 1'b1;
      end
      GOT1: if (evt) begin
        if (evt_code == CODE1) state_n = GOT2;
        else                   go_err  = 1'b1;
      end
      GOT2: if (evt) begin
        if (evt_code == CODE2) begin
          state_n = OPEN;
          fail_n  = '0;
`ifdef DOOR_LOCK_AUTO_RELOCK_EN
          timer_n = UNLOCK_LOAD;
`endif
        end else begin
          go_err = 1'b1;
        end
      end
`ifdef DOOR_LOCK_AUTO_RELOCK_EN
      OPEN: begin
        if (evt || timer == '0) state_n = IDLE;
        else                    timer_n = timer - TW'(1);
      end
`else
      OPEN: if (evt) state_n = IDLE;
`endif
      ERR: begin
        if (timer == '0) begin
          if (fail_cnt >= FAIL_MAX) begin
            state_n = LOCKOUT;
            timer_n = LOCK_LOAD;
          end else begin
            state_n = IDLE;
          end
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      LOCKOUT: begin
        if (timer == '0) begin
          state_n = IDLE;
          fail_n  = '0;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
    // Every wrong entry funnels through here so the fail count stays consistent
    if (go_err) begin
      state_n = ERR;
      timer_n = ERR_LOAD;
      fail_n  = (fail_cnt >= FAIL_MAX) ? fail_cnt : fail_cnt + FW'(1);
    end
  end

  assign locked   = (state != OPEN);
  assign unlocked = (state == OPEN);
  assign error    = (state == ERR) || (state == LOCKOUT);

endmodule

// File: tb/tb_door_lock_ctrl.sv
// Directed bench for door_lock_ctrl; outputs checked as {locked,unlocked,error}.
module tb_door_lock_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] key;
  logic       locked, unlocked, error;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [2:0] LK = 3'b100;
  localparam logic [2:0] OP = 3'b010;
  localparam logic [2:0] ER = 3'b101;

  door_lock_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .key      (key),
    .locked   (locked),
    .unlocked (unlocked),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [2:0] exp);
    logic [2:0] obs;
    obs = {locked, unlocked, error};
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    key = 8'h00;
    #3 chk("reset", LK);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Correct entry with held / repeated D9
    tickn(5);                   chk("idle_00", LK);
    key = 8'h48; tick();        chk("got1", LK);
    tickn(4);
    key = 8'hD9; tick();        chk("got2", LK);
    tickn(9);                   chk("d9_held", LK);
    key = 8'hC1; tick();        chk("open_c1", OP);
    tickn(4);                   chk("open_held", OP);
    key = 8'hED; tick();        chk("relock", LK);
    key = 8'h00; tick();

    // Single wrong code: exactly 4 error cycles
    key = 8'h12; tick();        chk("err_enter", ER);
    for (int i = 1; i < 4; i++) begin
      tick();                   chk("err_hold", ER);
    end
    tick();                     chk("err_exit", LK);
    key = 8'h00; tick();
    key = 8'h48; tick();
    key = 8'hD9; tick();        chk("reopen_got2", LK);
    key = 8'hC1; tick();        chk("reopen", OP);
    key = 8'h00; tick();        chk("open_00", OP);
    key = 8'hED; tick();        chk("relock2", LK);
    key = 8'h00; tick();

    // Three wrong entries -> lockout
    key = 8'h12; tick();        chk("fail1_err", ER);
    tickn(4);                   chk("fail1_idle", LK);
    key = 8'h00; tick();
    key = 8'h34; tick();        chk("fail2_err", ER);
    tickn(4);                   chk("fail2_idle", LK);
    key = 8'h00; tick();
    key = 8'h56; tick();        chk("fail3_err", ER);
    tickn(3);                   chk("fail3_err_end", ER);
    tick();                     chk("lockout_enter", ER);
    key = 8'h48; tick();        chk("lockout_ignore", ER);
    key = 8'h00;
    for (int i = 6; i < 20; i++) begin
      tick();                   chk("lockout_hold", ER);
    end
    tick();                     chk("lockout_exit", LK);
    key = 8'h48; tick();        chk("post_lock_got1", LK);
    key = 8'hD9; tick();        chk("post_lock_got2", LK);
    key = 8'hC1; tick();        chk("post_lock_open", OP);
    key = 8'h00; tick();
    key = 8'hED; tick();        chk("relock3", LK);
    key = 8'h00; tick();

    // Wrong third code mid-sequence
    key = 8'h48; tick();
    key = 8'hD9; tick();
    key = 8'h77; tick();        chk("mid_err", ER);
    tickn(4);                   chk("mid_err_exit", LK);
    key = 8'h00; tick();

    // Async reset from GOT2; C1 held through release is one event from IDLE
    key = 8'h48; tick();
    key = 8'hD9; tick();
    #2 rst = 1'b0;
    #1 chk("async_rst_got2", LK);
    key = 8'hC1;
    @(negedge clk); @(negedge clk);
    chk("rst_held", LK);
    rst = 1'b1;
    tick();                     chk("c1_after_rst", ER);
    tickn(4);                   chk("c1_err_exit", LK);

    // Async reset during ERR drops error without a clock edge
    key = 8'h00; tick();
    key = 8'h12; tick();        chk("err_before_rst", ER);
    #2 rst = 1'b0;
    #1 chk("async_rst_err", LK);
    key = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    tick();                     chk("after_rst_idle", LK);

    // Final open, then hold key
    key = 8'h48; tick();
    key = 8'hD9; tick();
    key = 8'hC1; tick();        chk("final_open", OP);
`ifdef DOOR_LOCK_AUTO_RELOCK_EN
    tickn(31);                  chk("auto_open_last", OP);
    tick();                     chk("auto_relock", LK);
`else
    tickn(40);                  chk("open_no_timeout", OP);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/door_lock_ctrl.md
Name: door_lock_ctrl

Overview:
- Three-code combination lock controller; samples an 8-bit keypad code every clock.
- A correct ordered sequence of three distinct key events opens the door.
- Wrong entries raise error; repeated failures force a timed lockout.
- Sits between the keypad decoder and the door actuator/status LEDs.

Parameters:
- CODE0, 8'h48, first combination code
- CODE1, 8'hD9, second combination code
- CODE2, 8'hC1, third combination code
- ERR_CYCLES, 4, cycles error state is held before returning to idle (>=1)
- MAX_FAILS, 3, consecutive wrong entries that trigger lockout (>=1)
- LOCKOUT_CYCLES, 16, lockout duration in cycles (>=1)
- UNLOCK_CYCLES, 32, auto-relock timeout; used only with the optional feature

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-low reset
- key  input  8  keypad code; 8'h00 means no key
- locked  output  1  door locked
- unlocked  output  1  door open
- error  output  1  wrong entry or lockout in progress

Behaviour:
- Interface: one clock, clk; rst is asynchronous, active-low.
- Reset (rst=0): state=IDLE, key_q=8'h00, fail_cnt=0, timer=0. Outputs: locked=1, unlocked=0, error=0.
- key_q registers key every cycle.
- Key event: key != key_q and key != 8'h00, evaluated at a rising edge.
  - A held or repeated value is a single event.
  - Returning to 00 is not an event.
- Moore FSM. Outputs decode directly from the state register, so they change at the same edge as the state. Latency from event edge to output change is 0 cycles after that edge.
- States:
  - IDLE: event==CODE0 -> GOT1; any other event -> ERR.
  - GOT1: event==CODE1 -> GOT2; other event -> ERR.
  - GOT2: event==CODE2 -> OPEN and fail_cnt=0; other event -> ERR.
  - OPEN: any event -> IDLE (relock).
  - ERR: on entry, fail_cnt += 1 and timer loads ERR_CYCLES-1.
    - Counts down; events are ignored.
    - At timer==0: go to LOCKOUT if fail_cnt >= MAX_FAILS, else IDLE.
  - LOCKOUT: timer loads LOCKOUT_CYCLES-1 on entry; events are ignored.
    - At timer==0: fail_cnt=0, go to IDLE.
- Outputs by state:
  - locked=1 in every state except OPEN.
  - unlocked=1 only in OPEN.
  - error=1 only in ERR and LOCKOUT.
  - Invariant: locked and unlocked are never equal.
- No event, including in GOT1/GOT2: hold state indefinitely (no entry timeout).
- Widths:
  - fail_cnt saturates at MAX_FAILS.
  - timer width = $clog2(max(ERR_CYCLES, LOCKOUT_CYCLES, UNLOCK_CYCLES)+1).
- Reset asserted mid-sequence or mid-lockout: immediate return to reset values; the next cycle after release starts from IDLE.
- key_q resets to 00, so a nonzero key held through reset release produces one event on the first active edge.
- Unknown/illegal state encoding: recover to IDLE.

Optional Feature:
- Macro DOOR_LOCK_AUTO_RELOCK_EN.
- Defined: OPEN loads timer with UNLOCK_CYCLES-1 on entry and returns to IDLE when it reaches 0. An event still relocks immediately.
- Undefined: OPEN is held until a key event. UNLOCK_CYCLES is unused and no timer logic is added for OPEN.

Decomposition:
- Package door_lock_pkg holds:
  - state enum (IDLE, GOT1, GOT2, OPEN, ERR, LOCKOUT)
  - KEY_NONE=8'h00
  - default code constants
- One sub-module: door_lock_key_event. It contains the key_q register and the event/value detector, with outputs evt and evt_code.
- FSM, counters and timer stay in the top module.

Test Plan:
- Reset then correct entry: key 00, 48, D9, D9 (held/repeated), C1, each held 5 cycles -> unlocked=1, locked=0 from the C1 event edge. Repeated D9 produces no extra event.
- Relock: from OPEN apply key ED -> locked=1, unlocked=0, error=0 at that edge.
- Wrong code: from IDLE apply 12 -> error=1 for exactly ERR_CYCLES=4 cycles, then IDLE. Then 48, D9, C1 still opens.
- Lockout: three wrong entries (12, 34, 56, with 00 between) -> the third ERR leads to error=1 for LOCKOUT_CYCLES=16 more cycles. Key 48 applied during lockout is ignored. Afterwards the correct sequence opens.
- Mid-sequence error and async reset: 48, D9, 77 -> ERR. Also 48, D9 then rst=0 asynchronously between edges -> outputs return to locked=1/unlocked=0/error=0 immediately, and C1 after release -> ERR (not OPEN).
- With DOOR_LOCK_AUTO_RELOCK_EN: open, then hold key C1 -> unlocked drops after UNLOCK_CYCLES=32 cycles.
